// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: orders clock, reset and AXI isolation on wake and
// shutdown for each cluster independently, with a sticky isolation-ack timeout.

module chimera_cluster_pwr_seq_lane #(
    parameter int RstCycles  = 4,
    parameter int IsoTimeout = 256,
    parameter int CntWidth   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_req,
    input  logic       iso_ack,
    input  logic       timeout_clr,
    output logic       iso,
    output logic       clk_en,
    output logic       clu_rst,
    output logic       busy,
    output logic       timeout,
    output logic [2:0] state
);
    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_WAKE  = 3'd1;
    localparam logic [2:0] ST_DEISO = 3'd2;
    localparam logic [2:0] ST_ON    = 3'd3;
    localparam logic [2:0] ST_ISO   = 3'd4;
    localparam logic [2:0] ST_GATE  = 3'd5;

    localparam logic [CntWidth-1:0] RST_LAST = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0] TO_LAST  = CntWidth'(IsoTimeout - 1);

    logic [2:0]          state_q, state_d;
    logic [CntWidth-1:0] cnt_q;
    logic                timeout_q;
    logic                forced;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter only runs in the timed states and restarts on every transition
            if (state_d != state_q || state_q == ST_OFF || state_q == ST_ON)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (forced)
                timeout_q <= 1'b1;
            else if (timeout_clr)
                timeout_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        forced  = 1'b0;
        case (state_q)
            ST_OFF:   if (en_req) state_d = ST_WAKE;
            ST_WAKE:  if (cnt_q == RST_LAST) state_d = ST_DEISO;
            ST_DEISO: begin
                if (!iso_ack) begin
                    state_d = ST_ON;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_ON;
                    forced  = 1'b1;
                end
            end
            ST_ON:    if (!en_req) state_d = ST_ISO;
            ST_ISO: begin
                if (iso_ack) begin
                    state_d = ST_GATE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_GATE;
                    forced  = 1'b1;
                end
            end
            ST_GATE:  if (cnt_q == RST_LAST) state_d = ST_OFF;
            // Illegal encodings recover through the safe shutdown tail
            default:  state_d = ST_GATE;
        endcase
    end

    always_comb begin
        iso     = 1'b1;
        clk_en  = 1'b1;
        clu_rst = 1'b1;
        busy    = 1'b1;
        case (state_q)
            ST_OFF:   begin clk_en = 1'b0; busy = 1'b0; end
            ST_WAKE:  ;
            ST_DEISO: begin iso = 1'b0; clu_rst = 1'b0; end
            ST_ON:    begin iso = 1'b0; clu_rst = 1'b0; busy = 1'b0; end
            ST_ISO:   clu_rst = 1'b0;
            default:  ;
        endcase
    end

    assign timeout = timeout_q;
    assign state   = state_q;
endmodule

module chimera_cluster_pwr_seq #(
    parameter int NumClusters = 5,
    parameter int RstCycles   = 4,
    parameter int IsoTimeout  = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumClusters-1:0]   en_req_i,
    input  logic [NumClusters-1:0]   iso_ack_i,
    input  logic [NumClusters-1:0]   timeout_clr_i,
    output logic [NumClusters-1:0]   iso_o,
    output logic [NumClusters-1:0]   clk_en_o,
    output logic [NumClusters-1:0]   clu_rst_o,
    output logic [NumClusters-1:0]   busy_o,
    output logic [NumClusters-1:0]   timeout_o,
    output logic [3*NumClusters-1:0] state_o
);
    localparam int CntMax   = (RstCycles > IsoTimeout) ? RstCycles : IsoTimeout;
    localparam int CntWidth = $clog2(CntMax + 1);

    for (genvar i = 0; i < NumClusters; i++) begin : g_lane
        chimera_cluster_pwr_seq_lane #(
            .RstCycles (RstCycles),
            .IsoTimeout(IsoTimeout),
            .CntWidth  (CntWidth)
        ) u_lane (
            .clk        (clk_i),
            .rst        (rst_i),
            .en_req     (en_req_i[i]),
            .iso_ack    (iso_ack_i[i]),
            .timeout_clr(timeout_clr_i[i]),
            .iso        (iso_o[i]),
            .clk_en     (clk_en_o[i]),
            .clu_rst    (clu_rst_o[i]),
            .busy       (busy_o[i]),
            .timeout    (timeout_o[i]),
            .state      (state_o[3*i +: 3])
        );
    end
endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Scenario bench for chimera_cluster_pwr_seq: timed per-cluster expectations are queued
// at stimulus time and compared against the outputs when their cycle arrives.

module tb_chimera_cluster_pwr_seq;
    localparam int N  = 5;
    localparam int RC = 4;
    localparam int TO = 8;

    localparam logic [2:0] OFF = 3'd0, WAKE = 3'd1, DEISO = 3'd2, ON = 3'd3, ISO = 3'd4, GATE = 3'd5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   en, ack, clr;
    logic [N-1:0]   iso, clk_en, clu_rst, busy, tmo;
    logic [3*N-1:0] st;

    chimera_cluster_pwr_seq #(
        .NumClusters(N),
        .RstCycles  (RC),
        .IsoTimeout (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_req_i     (en),
        .iso_ack_i    (ack),
        .timeout_clr_i(clr),
        .iso_o        (iso),
        .clk_en_o     (clk_en),
        .clu_rst_o    (clu_rst),
        .busy_o       (busy),
        .timeout_o    (tmo),
        .state_o      (st)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         cyc;
        int         clu;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, want %h", tag, cyc, act, exp);
        end
    endtask

    // {state, iso, clk_en, rst, busy, timeout} straight from the state/output table
    function automatic logic [7:0] pk(input logic [2:0] s, input logic t);
        logic [2:0] o;
        logic       b;
        case (s)
            OFF:       o = 3'b101;
            WAKE:      o = 3'b111;
            DEISO, ON: o = 3'b010;
            ISO:       o = 3'b110;
            default:   o = 3'b111;
        endcase
        b = (s != OFF) && (s != ON);
        return {s, o, b, t};
    endfunction

    task automatic expect_at(input int c, input int clu, input logic [2:0] s, input logic t, input string tag);
        exp_t e;
        int   i;
        e.cyc = c; e.clu = clu; e.val = pk(s, t);
        e.tag = $sformatf("%s[c%0d]", tag, clu);
        i = 0;
        while (i < sbq.size() && sbq[i].cyc <= c) i++;
        sbq.insert(i, e);
    endtask

    task automatic expect_rng(input int c0, input int c1, input int clu, input logic [2:0] s,
                              input logic t, input string tag);
        for (int c = c0; c <= c1; c++) expect_at(c, clu, s, t, tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int c);
        while (cyc < c) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            chk(e.tag, {st[3*e.clu +: 3], iso[e.clu], clk_en[e.clu], clu_rst[e.clu],
                        busy[e.clu], tmo[e.clu]}, e.val);
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < N; i++) begin
                assert (clk_en[i] || clu_rst[i])
                    else $error("FAIL rst_released_while_gated c%0d", i);
                assert (clu_rst[i] || clk_en[i])
                    else $error("FAIL gated_while_rst_deasserted c%0d", i);
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1; en = '0; ack = '1; clr = '0;
        step(); step(); step();

        // reset state, then 20 idle cycles
        t = cyc;
        for (int i = 0; i < N; i++) expect_at(t, i, OFF, 1'b0, "reset");
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            expect_at(t + 1, i, OFF, 1'b0, "idle");
            expect_at(t + 10, i, OFF, 1'b0, "idle");
            expect_at(t + 20, i, OFF, 1'b0, "idle");
        end
        go(t + 21);

        // cluster 2 wake, ack drops at t+6
        t = cyc;
        en[2] = 1'b1;
        expect_rng(t + 1, t + 4, 2, WAKE, 1'b0, "a_wake");
        expect_rng(t + 5, t + 6, 2, DEISO, 1'b0, "a_deiso");
        expect_at(t + 7, 2, ON, 1'b0, "a_on");
        for (int i = 0; i < N; i++) if (i != 2) begin
            expect_at(t + 4, i, OFF, 1'b0, "a_other");
            expect_at(t + 7, i, OFF, 1'b0, "a_other");
        end
        go(t + 6);
        ack[2] = 1'b0;
        go(t + 8);

        // cluster 0 minimum wake, then shutdown with ack at t+3
        t = cyc;
        en[0] = 1'b1; ack[0] = 1'b0;
        expect_rng(t + 1, t + 4, 0, WAKE, 1'b0, "b_wake");
        expect_at(t + 5, 0, DEISO, 1'b0, "b_deiso");
        expect_at(t + 6, 0, ON, 1'b0, "b_on_min");
        go(t + 6);
        t = cyc;
        en[0] = 1'b0;
        expect_rng(t + 1, t + 3, 0, ISO, 1'b0, "b_iso");
        expect_rng(t + 4, t + 7, 0, GATE, 1'b0, "b_gate");
        expect_at(t + 8, 0, OFF, 1'b0, "b_off");
        go(t + 3);
        ack[0] = 1'b1;
        go(t + 9);

        // cluster 4 shutdown with ack stuck low: ISO timeout, coincident and later clear
        t = cyc;
        en[4] = 1'b1; ack[4] = 1'b0;
        go(t + 6);
        t = cyc;
        en[4] = 1'b0;
        expect_at(t, 4, ON, 1'b0, "c_on");
        expect_rng(t + 1, t + 8, 4, ISO, 1'b0, "c_iso");
        expect_rng(t + 9, t + 10, 4, GATE, 1'b1, "c_to_set");
        expect_rng(t + 11, t + 12, 4, GATE, 1'b0, "c_to_clr");
        expect_at(t + 13, 4, OFF, 1'b0, "c_off");
        go(t + 8);
        clr[4] = 1'b1;
        step();
        clr[4] = 1'b0;
        go(t + 10);
        clr[4] = 1'b1;
        step();
        clr[4] = 1'b0;
        go(t + 14);

        // cluster 3 wake with ack stuck high: DEISO timeout, then quick shutdown
        t = cyc;
        en[3] = 1'b1;
        expect_rng(t + 1, t + 4, 3, WAKE, 1'b0, "d_wake");
        expect_rng(t + 5, t + 12, 3, DEISO, 1'b0, "d_deiso");
        expect_at(t + 13, 3, ON, 1'b1, "d_on_to");
        go(t + 13);
        t = cyc;
        en[3] = 1'b0;
        expect_at(t + 1, 3, ISO, 1'b1, "d_iso");
        expect_rng(t + 2, t + 5, 3, GATE, 1'b1, "d_gate");
        expect_at(t + 6, 3, OFF, 1'b1, "d_off_sticky");
        go(t + 7);

        // cluster 1 request dropped during WAKE; reset while c1 in ISO and c3 in WAKE
        t = cyc;
        en[1] = 1'b1; ack[1] = 1'b0;
        expect_rng(t + 1, t + 4, 1, WAKE, 1'b0, "e_wake");
        expect_at(t + 5, 1, DEISO, 1'b0, "e_deiso");
        expect_at(t + 6, 1, ON, 1'b0, "e_on");
        expect_rng(t + 7, t + 9, 1, ISO, 1'b0, "e_iso");
        expect_rng(t + 8, t + 9, 3, WAKE, 1'b1, "e_c3_wake");
        for (int i = 0; i < N; i++) expect_at(t + 10, i, OFF, 1'b0, "e_rst");
        expect_at(t + 11, 2, WAKE, 1'b0, "e_rewake");
        go(t + 2);
        en[1] = 1'b0;
        go(t + 7);
        en[3] = 1'b1;
        go(t + 9);
        rst = 1'b1; en[3] = 1'b0;
        step();
        rst = 1'b0;
        go(t + 12);

        for (int k = 0; k < 20 && sbq.size() > 0; k++) step();
        chk("drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
